// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Writeback-stage data memory request/response bundle.
//   Request  (core -> memory): MemWriteW, RegWE_W_W, StallW, funct3W, AddrW,
//                              WriteDataW, A3_W
//   Response (memory -> core): ReadDataW2, RegWE_W_W2, A3_W2
// The master modport is the core side; the slave modport is the responder.
interface dmem_responder_if;
  logic        MemWriteW;
  logic        RegWE_W_W;
  logic        StallW;
  logic [2:0]  funct3W;
  logic [31:0] AddrW;
  logic [31:0] WriteDataW;
  logic [4:0]  A3_W;
  logic [31:0] ReadDataW2;
  logic        RegWE_W_W2;
  logic [4:0]  A3_W2;

  modport master (
    output MemWriteW, RegWE_W_W, StallW, funct3W, AddrW, WriteDataW, A3_W,
    input  ReadDataW2, RegWE_W_W2, A3_W2
  );

  modport slave (
    input  MemWriteW, RegWE_W_W, StallW, funct3W, AddrW, WriteDataW, A3_W,
    output ReadDataW2, RegWE_W_W2, A3_W2
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Single-port word-organised data memory answering Writeback-stage loads and
// stores. Stores commit on the accepting edge; load results are registered
// into the W2 stage one cycle later. Misaligned/illegal accesses are flagged.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   bus          : request/response bundle (slave side)
//   err          : sticky access-error flag
//   err_addr     : address of the first erroring access
//   load_count   : accepted loads (wraps at 2^16)
//   store_count  : accepted stores (wraps at 2^16)
module dmem_responder #(
  parameter int DEPTH = 1024
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output logic               err,
  output logic [31:0]        err_addr,
  output logic [15:0]        load_count,
  output logic [15:0]        store_count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [0:DEPTH-1];
  logic [31:0]   r_rdata;
  logic          r_valid;
  logic [4:0]    r_a3;
  logic          r_err;
  logic [31:0]   r_err_addr;
  logic [15:0]   r_load_cnt;
  logic [15:0]   r_store_cnt;

  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_ld_ok;
  logic          w_st_ok;
  logic          w_aligned;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_ext;
  logic          w_accept;
  logic          w_both;
  logic          w_bad;
  logic          w_wr_en;
  logic          w_unused;

  // Upper address bits alias onto the same words.
  assign w_idx    = bus.AddrW[AW+1:2];
  assign w_unused = ^bus.AddrW[31:AW+2];
  assign w_word   = r_mem[w_idx];
  assign w_half   = bus.AddrW[1] ? w_word[31:16] : w_word[15:0];

  // Byte lane picked out of the addressed word.
  always_comb begin
    w_byte = 8'h00;
    case (bus.AddrW[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      2'b11:   w_byte = w_word[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  // Decode size/sign into legality, alignment, byte enables and load extension.
  always_comb begin
    w_ld_ok   = 1'b0;
    w_st_ok   = 1'b0;
    w_aligned = 1'b0;
    w_be      = 4'b0000;
    w_wdata   = 32'h0000_0000;
    w_ext     = 32'h0000_0000;
    case (bus.funct3W)
      3'b000: begin
        w_ld_ok   = 1'b1;
        w_st_ok   = 1'b1;
        w_aligned = 1'b1;
        w_be      = 4'b0001 << bus.AddrW[1:0];
        w_wdata   = {4{bus.WriteDataW[7:0]}};
        w_ext     = {{24{w_byte[7]}}, w_byte};
      end
      3'b001: begin
        w_ld_ok   = 1'b1;
        w_st_ok   = 1'b1;
        w_aligned = ~bus.AddrW[0];
        w_be      = bus.AddrW[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{bus.WriteDataW[15:0]}};
        w_ext     = {{16{w_half[15]}}, w_half};
      end
      3'b010: begin
        w_ld_ok   = 1'b1;
        w_st_ok   = 1'b1;
        w_aligned = (bus.AddrW[1:0] == 2'b00);
        w_be      = 4'b1111;
        w_wdata   = bus.WriteDataW;
        w_ext     = w_word;
      end
      3'b100: begin
        w_ld_ok   = 1'b1;
        w_aligned = 1'b1;
        w_ext     = {24'h00_0000, w_byte};
      end
      3'b101: begin
        w_ld_ok   = 1'b1;
        w_aligned = ~bus.AddrW[0];
        w_ext     = {16'h0000, w_half};
      end
      default: begin
        w_ld_ok   = 1'b0;
        w_st_ok   = 1'b0;
      end
    endcase
  end

  assign w_accept = ~bus.StallW & (bus.MemWriteW | bus.RegWE_W_W);
  assign w_both   = bus.MemWriteW & bus.RegWE_W_W;
  // With both requests high the access is handled as an erroring load.
  assign w_bad    = w_both | ~w_aligned |
                    (bus.RegWE_W_W ? ~w_ld_ok : ~w_st_ok);
  assign w_wr_en  = ~reset & w_accept & bus.MemWriteW & ~bus.RegWE_W_W & ~w_bad;

  // Memory array: byte-lane writes, contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en && w_be[i]) begin
        r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // W2 result stage, error capture and access counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata     <= 32'h0000_0000;
      r_valid     <= 1'b0;
      r_a3        <= 5'd0;
      r_err       <= 1'b0;
      r_err_addr  <= 32'h0000_0000;
      r_load_cnt  <= 16'h0000;
      r_store_cnt <= 16'h0000;
    end else if (w_accept) begin
      r_valid <= bus.RegWE_W_W;
      if (bus.RegWE_W_W) begin
        r_rdata    <= w_bad ? 32'h0000_0000 : w_ext;
        r_a3       <= bus.A3_W;
        r_load_cnt <= r_load_cnt + 16'h0001;
      end else begin
        r_store_cnt <= r_store_cnt + 16'h0001;
      end
      if (w_bad) begin
        r_err <= 1'b1;
        if (!r_err) begin
          r_err_addr <= bus.AddrW;
        end
      end
    end else if (!bus.StallW) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign bus.ReadDataW2 = r_rdata;
  assign bus.RegWE_W_W2 = r_valid;
  assign bus.A3_W2      = r_a3;
  assign err            = r_err;
  assign err_addr       = r_err_addr;
  assign load_count     = r_load_cnt;
  assign store_count    = r_store_cnt;

endmodule
